pipe_stage_reg: RTL

- Parametrised pipeline stage register; successor to the fixed-width stage registers between decode/execute and later stages.
- Carries NUM_DATA data lanes plus control bundle and destination register across one stage, with valid/ready handshake and a two-entry skid buffer.
- Flush inserts a bubble: control is forced to zero, so no write side effects.
- Saturating bubble counter for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: NUM_DATA lanes plus control bundle and rd, valid/ready
// handshake with optional two-entry skid buffer, flush-to-bubble and bubble counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_DATA = 4,
    parameter int unsigned CTRL_W   = 8,
    parameter int unsigned RD_W     = 5,
    parameter int unsigned SKID_EN  = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [RD_W-1:0]            in_rd,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [RD_W-1:0]            out_rd,
    output logic                       skid_full,
    output logic [CNT_W-1:0]           bubble_cnt
);
    localparam int unsigned PAY_W = NUM_DATA * DATA_W;
    localparam bit USE_SKID = (SKID_EN != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PAY_W-1:0]  main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [RD_W-1:0]   main_rd_q, main_rd_d;
    logic [PAY_W-1:0]  skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [RD_W-1:0]   skid_rd_q, skid_rd_d;
    logic [CNT_W-1:0]  bubble_cnt_q;
    logic              main_valid;
    logic              in_xfer;

    assign main_valid = (state_q != ST_EMPTY);
    // Skid mode: ready comes from state only; single-entry mode passes out_ready through.
    assign in_ready   = USE_SKID ? (state_q != ST_SKID) : (!main_valid || out_ready);
    assign in_xfer    = in_valid && in_ready;

    assign out_valid  = main_valid;
    assign out_data   = main_data_q;
    assign out_ctrl   = main_ctrl_q & {CTRL_W{main_valid}};
    assign out_rd     = main_rd_q & {RD_W{main_valid}};
    assign skid_full  = USE_SKID && (state_q == ST_SKID);
    assign bubble_cnt = bubble_cnt_q;

    // Next-state and entry movement
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        main_rd_d   = main_rd_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_rd_d   = skid_rd_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            main_rd_d   = '0;
            skid_ctrl_d = '0;
            skid_rd_d   = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        main_rd_d   = in_rd;
                        state_d     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_ready) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        main_rd_d   = in_rd;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end else if (in_xfer) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        skid_rd_d   = in_rd;
                        state_d     = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        main_rd_d   = skid_rd_q;
                        skid_ctrl_d = '0;
                        skid_rd_d   = '0;
                        state_d     = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            main_rd_q   <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            main_rd_q   <= main_rd_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_rd_q   <= skid_rd_d;
        end
    end

    // Saturating count of cycles with no valid output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_q <= '0;
        end else if (!main_valid && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

endmodule
